// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg: shared word types, boolean constants and fetcher state encodings
package instruction_fetcher_pkg;
  localparam int WORD_RANGE = 32;
  typedef logic [WORD_RANGE-1:0] word_t;
  localparam word_t ZERO_WORD = '0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic {FETCH = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/instruction_fetcher_icache.sv
// icache_direct_mapped: one-word-line direct-mapped cache, combinational read, synchronous write
module icache_direct_mapped
  import instruction_fetcher_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output word_t                 rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  word_t                 wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  word_t               data [LINES];
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_data = data[rd_index];
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (we) valid[wr_index] <= TRUE;
  end
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end
endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: PC, icache lookup, miss refill via memory controller, rollback redirect
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int          ICACHE_INDEX_BITS = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rob_rollback_in,
  input  logic [31:0] rob_rollback_pc_in,
  output logic        mc_request_out,
  output logic [31:0] mc_address_out,
  input  logic        mc_ready_in,
  input  logic [31:0] mc_instruction_in,
  input  logic        iq_full_in,
  output logic        iq_valid_out,
  output logic [31:0] iq_instruction_out,
  output logic [31:0] iq_pc_out
);
  localparam int TAG_BITS = 32 - ICACHE_INDEX_BITS - 2;
  state_t                       state;
  word_t                        pc;
  logic                         line_valid;
  logic [TAG_BITS-1:0]          line_tag;
  word_t                        line_data;
  logic [ICACHE_INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]          tag;
  logic                         hit;
  logic                         fill;
  assign index = pc[ICACHE_INDEX_BITS+1:2];
  assign tag = pc[31:ICACHE_INDEX_BITS+2];
  assign hit = line_valid && (line_tag == tag);
  // A ready pulse coinciding with rollback belongs to the abandoned path and is dropped.
  assign fill = (state == WAIT) && mc_ready_in && !rob_rollback_in;
  icache_direct_mapped #(.INDEX_BITS(ICACHE_INDEX_BITS), .TAG_BITS(TAG_BITS)) u_icache (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .we       (fill),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (mc_instruction_in)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      mc_request_out <= FALSE;
      mc_address_out <= ZERO_WORD;
      iq_valid_out <= FALSE;
      iq_instruction_out <= ZERO_WORD;
      iq_pc_out <= ZERO_WORD;
    end else begin
      mc_request_out <= FALSE;
      iq_valid_out <= FALSE;
      if (rob_rollback_in) begin
        pc <= rob_rollback_pc_in;
        state <= FETCH;
      end else if (state == FETCH && !iq_full_in) begin
        if (hit) begin
          iq_valid_out <= TRUE;
          iq_instruction_out <= line_data;
          iq_pc_out <= pc;
          pc <= pc + 32'd4;
        end else begin
          mc_request_out <= TRUE;
          mc_address_out <= pc;
          state <= WAIT;
        end
      end else if (state == WAIT && mc_ready_in) begin
        state <= FETCH;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed scoreboard bench with a latency-modelled memory controller
module tb_instruction_fetcher;
  logic        clk = 0;
  logic        rst = 1;
  logic        rob_rollback_in = 0;
  logic [31:0] rob_rollback_pc_in = 0;
  logic        mc_request_out;
  logic [31:0] mc_address_out;
  logic        mc_ready_in = 0;
  logic [31:0] mc_instruction_in = 0;
  logic        iq_full_in = 1;
  logic        iq_valid_out;
  logic [31:0] iq_instruction_out;
  logic [31:0] iq_pc_out;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_del = 0;
  int ready_cyc = 0;
  int del_cyc = 0;
  logic [31:0] req_q [$];
  logic [31:0] del_pc_q [$];
  logic [31:0] del_ins_q [$];
  bit          busy = 0;
  int          cnt = 0;
  logic [31:0] pend = 0;

  instruction_fetcher dut (
    .clk(clk), .rst(rst),
    .rob_rollback_in(rob_rollback_in), .rob_rollback_pc_in(rob_rollback_pc_in),
    .mc_request_out(mc_request_out), .mc_address_out(mc_address_out),
    .mc_ready_in(mc_ready_in), .mc_instruction_in(mc_instruction_in),
    .iq_full_in(iq_full_in), .iq_valid_out(iq_valid_out),
    .iq_instruction_out(iq_instruction_out), .iq_pc_out(iq_pc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Controller model: ready three cycles after the request, dropped on rst or rollback.
  always @(posedge clk) begin
    #1;
    mc_ready_in = 0;
    if (rst || rob_rollback_in) busy = 0;
    else if (busy) begin
      if (cnt == 0) begin
        mc_ready_in = 1;
        mc_instruction_in = mem(pend);
        busy = 0;
      end else cnt--;
    end
    if (mc_request_out) begin
      busy = 1;
      pend = mc_address_out;
      cnt = 2;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mc_ready_in) ready_cyc = cyc;
      if (mc_request_out) begin
        chk("req_expected", req_q.size() > 0, 1);
        if (req_q.size() > 0) chk("req_addr", mc_address_out, req_q.pop_front());
      end
      if (iq_valid_out) begin
        n_del++;
        del_cyc = cyc;
        chk("del_expected", del_pc_q.size() > 0, 1);
        if (del_pc_q.size() > 0) begin
          chk("del_pc", iq_pc_out, del_pc_q.pop_front());
          chk("del_instr", iq_instruction_out, del_ins_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_del(input logic [31:0] pc);
    del_pc_q.push_back(pc);
    del_ins_q.push_back(mem(pc));
  endtask

  task automatic run_until_del(input int k);
    int start;
    start = n_del;
    iq_full_in = 0;
    for (int i = 0; i < 200 && n_del < start + k; i++) tick();
    iq_full_in = 1;
    chk("del_count", n_del - start, k);
  endtask

  task automatic rollback(input logic [31:0] pc);
    rob_rollback_in = 1;
    rob_rollback_pc_in = pc;
    tick();
    rob_rollback_in = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", iq_valid_out, 0);
    chk("rst_req", mc_request_out, 0);
    chk("rst_addr", mc_address_out, 0);
    chk("rst_instr", iq_instruction_out, 0);
    chk("rst_pc", iq_pc_out, 0);
    rst = 0;
    tick();
    // cold start
    req_q.push_back(0);
    exp_del(0);
    run_until_del(1);
    chk("miss_latency", del_cyc - ready_cyc, 2);
    for (int i = 1; i < 4; i++) begin
      req_q.push_back(i * 4);
      exp_del(i * 4);
    end
    run_until_del(3);
    // loop re-execution from cache
    for (int i = 0; i < 4; i++) exp_del(i * 4);
    rollback(0);
    iq_full_in = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("loop_valid", iq_valid_out, 1);
      chk("loop_pc", iq_pc_out, i * 4);
      chk("loop_no_req", mc_request_out, 0);
    end
    iq_full_in = 1;
    // back-pressure
    for (int i = 0; i < 4; i++) exp_del(i * 4);
    rollback(0);
    iq_full_in = 0;
    tick();
    tick();
    chk("bp_pre_pc", iq_pc_out, 4);
    iq_full_in = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", iq_valid_out, 0);
    end
    iq_full_in = 0;
    tick();
    chk("bp_resume_valid", iq_valid_out, 1);
    chk("bp_resume_pc", iq_pc_out, 8);
    tick();
    chk("bp_next_pc", iq_pc_out, 12);
    iq_full_in = 1;
    // rollback coinciding with ready discards the fill
    req_q.push_back(32'h20);
    rollback(32'h20);
    iq_full_in = 0;
    for (int i = 0; i < 50 && !mc_ready_in; i++) tick();
    chk("ready_seen", mc_ready_in, 1);
    req_q.push_back(32'h100);
    exp_del(32'h100);
    rollback(32'h100);
    run_until_del(1);
    req_q.push_back(32'h20);
    exp_del(32'h20);
    rollback(32'h20);
    run_until_del(1);
    chk("refetch_latency", del_cyc - ready_cyc, 2);
    // conflict eviction on index 0
    req_q.push_back(32'h400);
    exp_del(32'h400);
    rollback(32'h400);
    run_until_del(1);
    req_q.push_back(0);
    exp_del(0);
    rollback(0);
    run_until_del(1);
    chk("evict_latency", del_cyc - ready_cyc, 2);
    // reset while waiting on the controller
    req_q.push_back(32'h40);
    rollback(32'h40);
    iq_full_in = 0;
    for (int i = 0; i < 50 && !mc_request_out; i++) tick();
    chk("wait_req_seen", mc_request_out, 1);
    rst = 1;
    tick();
    chk("wrst_valid", iq_valid_out, 0);
    chk("wrst_req", mc_request_out, 0);
    chk("wrst_addr", mc_address_out, 0);
    chk("wrst_instr", iq_instruction_out, 0);
    chk("wrst_pc", iq_pc_out, 0);
    rst = 0;
    req_q.push_back(0);
    exp_del(0);
    run_until_del(1);
    req_q.push_back(4);
    exp_del(4);
    run_until_del(1);
    repeat (3) tick();
    chk("req_q_empty", req_q.size(), 0);
    chk("del_q_empty", del_pc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
